// File: rtl/req_encoder32to5_if.sv
// Request-in / code-out bundle for the 32-to-5 encoder.
// The slave modport is the encoder side; the master modport is the requester/consumer side.
interface req_encoder32to5_if;
    logic        enable;
    logic [31:0] req_in;
    logic        out_ready;
    logic        out_valid;
    logic [4:0]  out_code;
    logic [31:0] out_onehot;
    logic [31:0] pending;

    modport slave (
        input  enable,
        input  req_in,
        input  out_ready,
        output out_valid,
        output out_code,
        output out_onehot,
        output pending
    );

    modport master (
        output enable,
        output req_in,
        output out_ready,
        input  out_valid,
        input  out_code,
        input  out_onehot,
        input  pending
    );
endinterface

// File: rtl/req_encoder32to5.sv
// Latches request pulses into a pending vector and serves them lowest-index first as a 5-bit code.
// Request to out_valid is 2 cycles from idle; out_code/out_valid hold stable while out_ready is low.
module req_encoder32to5 (
    input  logic                  clk,
    input  logic                  reset,
    req_encoder32to5_if.slave     bus
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pending;
    logic [4:0]  r_code;
    logic        r_valid;

    logic [4:0]  w_sel;
    logic        w_any;
    logic        w_load;
    logic        w_valid_nxt;
    logic [31:0] w_load_mask;
    logic [31:0] w_req_gated;
    logic [31:0] w_pending_nxt;

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        w_sel = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel = i[4:0];
            end
        end
    end

    assign w_any = |r_pending;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_valid_nxt = r_valid;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_load      = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (bus.out_ready) begin
                    if (w_any) begin
                        w_load      = 1'b1;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // New requests are OR-ed after the clear, so a request on the loaded bit stays pending.
    assign w_load_mask   = w_load ? (32'd1 << w_sel) : 32'd0;
    assign w_req_gated   = bus.enable ? bus.req_in : 32'd0;
    assign w_pending_nxt = (r_pending & ~w_load_mask) | w_req_gated;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pending <= 32'd0;
            r_code    <= 5'd0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_valid   <= w_valid_nxt;
            if (w_load) begin
                r_code <= w_sel;
            end
        end
    end

    assign bus.out_valid  = r_valid;
    assign bus.out_code   = r_code;
    assign bus.out_onehot = r_valid ? (32'd1 << r_code) : 32'd0;
    assign bus.pending    = r_pending;

endmodule

// File: tb/tb_req_encoder32to5.sv
// Self-checking bench for req_encoder32to5: directed vector table, hand-written corner
// sequences, then random traffic compared against a per-source pending-flag model.
module tb_req_encoder32to5;

    logic clk;
    logic reset;

    req_encoder32to5_if bus ();

    req_encoder32to5 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    typedef struct {
        logic        en;
        logic [31:0] req;
        logic        rdy;
        logic        exp_vld;
        logic [4:0]  exp_code;
        logic [31:0] exp_pend;
    } vec_t;

    vec_t tbl[14];

    // Reference model: one flag per source plus the item currently offered.
    bit m_pend[32];
    bit m_valid;
    int m_code;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [31:0] req, input logic rdy);
        bus.enable    = en;
        bus.req_in    = req;
        bus.out_ready = rdy;
    endtask

    function automatic logic [31:0] onehot_of(input logic vld, input logic [4:0] code);
        logic [31:0] v;
        v = 32'd0;
        if (vld) v[code] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_valid = 1'b0;
        m_code  = 0;
    endtask

    // An offer is replaced whenever nothing is offered or the current one is taken;
    // the replacement is the smallest waiting source. Arriving requests join afterwards.
    task automatic model_edge(input logic en, input logic [31:0] req, input logic rdy);
        int lo;
        lo = -1;
        if (!m_valid || rdy) begin
            for (int i = 31; i >= 0; i--) if (m_pend[i]) lo = i;
            if (lo >= 0) begin
                m_valid    = 1'b1;
                m_code     = lo;
                m_pend[lo] = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (en) for (int i = 0; i < 32; i++) if (req[i]) m_pend[i] = 1'b1;
    endtask

    function automatic logic [31:0] model_pend_vec();
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] rq;
        logic        en_r, rdy_r;
        n_chk  = 0;
        n_fail = 0;

        // Reset holds everything at zero even with all requests driven.
        reset = 1'b1;
        drive(1'b1, 32'hFFFF_FFFF, 1'b1);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
            chk("rst_pending", bus.pending, 32'd0);
            chk("rst_code", {27'd0, bus.out_code}, 32'd0);
            chk("rst_onehot", bus.out_onehot, 32'd0);
        end
        drive(1'b0, 32'd0, 1'b0);
        reset = 1'b0;
        tick();

        // Backpressure sequence, single request, then gated requests.
        tbl[0]  = '{1'b1, 32'h8000_0005, 1'b0, 1'b0, 5'd0,  32'h8000_0005};
        tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 5'd0,  32'h8000_0004};
        tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 5'd0,  32'h8000_0004};
        tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 5'd0,  32'h8000_0004};
        tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 5'd0,  32'h8000_0004};
        tbl[5]  = '{1'b0, 32'h0,         1'b1, 1'b1, 5'd2,  32'h8000_0000};
        tbl[6]  = '{1'b0, 32'h0,         1'b1, 1'b1, 5'd31, 32'h0};
        tbl[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 5'd0,  32'h0};
        tbl[8]  = '{1'b1, 32'h0001_0000, 1'b1, 1'b0, 5'd0,  32'h0001_0000};
        tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 5'd16, 32'h0};
        tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 5'd0,  32'h0};
        tbl[11] = '{1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0,  32'h0};
        tbl[12] = '{1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0,  32'h0};
        tbl[13] = '{1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0,  32'h0};

        for (int v = 0; v < 14; v++) begin
            drive(tbl[v].en, tbl[v].req, tbl[v].rdy);
            tick();
            chk($sformatf("tbl%0d_valid", v), {31'd0, bus.out_valid}, {31'd0, tbl[v].exp_vld});
            chk($sformatf("tbl%0d_pending", v), bus.pending, tbl[v].exp_pend);
            chk($sformatf("tbl%0d_onehot", v), bus.out_onehot, onehot_of(tbl[v].exp_vld, tbl[v].exp_code));
            if (tbl[v].exp_vld)
                chk($sformatf("tbl%0d_code", v), {27'd0, bus.out_code}, {27'd0, tbl[v].exp_code});
        end

        // One enabled cycle of all-ones drains as codes 0..31 in order.
        drive(1'b1, 32'hFFFF_FFFF, 1'b1);
        tick();
        drive(1'b0, 32'd0, 1'b1);
        tick();
        chk("full_pending", bus.pending, 32'hFFFF_FFFE);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("drain%0d_valid", k), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("drain%0d_code", k), {27'd0, bus.out_code}, k);
            tick();
        end
        chk("drain_end_valid", {31'd0, bus.out_valid}, 32'd0);

        // Requests on 3 and 1 while code 3 is being accepted: 1 then 3 follow.
        drive(1'b1, 32'h0000_0008, 1'b1);
        tick();
        drive(1'b0, 32'd0, 1'b1);
        tick();
        chk("sc_code3", {27'd0, bus.out_code}, 32'd3);
        drive(1'b1, 32'h0000_000A, 1'b1);
        tick();
        drive(1'b0, 32'd0, 1'b1);
        tick();
        chk("sc_next1", {27'd0, bus.out_code}, 32'd1);
        chk("sc_next1_valid", {31'd0, bus.out_valid}, 32'd1);
        tick();
        chk("sc_next3", {27'd0, bus.out_code}, 32'd3);
        chk("sc_next3_valid", {31'd0, bus.out_valid}, 32'd1);
        tick();
        chk("sc_end_valid", {31'd0, bus.out_valid}, 32'd0);

        // Request on the bit being loaded stays pending and is offered again.
        drive(1'b1, 32'h0000_0020, 1'b0);
        tick();
        tick();
        chk("sw_code5", {27'd0, bus.out_code}, 32'd5);
        chk("sw_pending", bus.pending, 32'h0000_0020);
        drive(1'b0, 32'd0, 1'b1);
        tick();
        chk("sw_again5", {27'd0, bus.out_code}, 32'd5);
        chk("sw_again_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("sw_again_pending", bus.pending, 32'd0);
        tick();
        chk("sw_end_valid", {31'd0, bus.out_valid}, 32'd0);

        // Asynchronous reset mid-offer with ten sources waiting.
        drive(1'b1, 32'h0000_03FF, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b0);
        tick();
        chk("ar_pre_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("ar_pre_pending", bus.pending, 32'h0000_03FE);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("ar_pending", bus.pending, 32'd0);
        chk("ar_code", {27'd0, bus.out_code}, 32'd0);
        chk("ar_onehot", bus.out_onehot, 32'd0);
        tick();
        reset = 1'b0;
        drive(1'b0, 32'd0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("ar_after_valid", {31'd0, bus.out_valid}, 32'd0);
        end

        // Random traffic against the model.
        drive(1'b0, 32'd0, 1'b0);
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0:       rq = 32'd0;
                1:       rq = $urandom & $urandom & $urandom;
                2:       rq = 32'd1 << $urandom_range(0, 31);
                default: rq = $urandom;
            endcase
            en_r  = ($urandom_range(0, 3) != 0);
            rdy_r = ($urandom_range(0, 2) != 0);
            drive(en_r, rq, rdy_r);
            model_edge(en_r, rq, rdy_r);
            tick();
            chk("rnd_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
            chk("rnd_pending", bus.pending, model_pend_vec());
            chk("rnd_onehot", bus.out_onehot, onehot_of(m_valid, m_code[4:0]));
            if (m_valid) chk("rnd_code", {27'd0, bus.out_code}, m_code);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/req_encoder32to5.md
# req_encoder32to5

Sequential 32-to-5 request encoder. It performs the inverse of the register-file 5-to-32 write-select decoder. Up to 32 single-cycle request lines are latched into a pending vector. Pending requests are served one at a time, lowest index first, and each one is presented as a 5-bit code plus a one-hot echo on a valid/ready handshake. It sits between per-register or per-source event lines and any consumer that needs a binary index, such as writeback arbitration or interrupt cause reporting.

## Interface
- No parameters. Width is fixed at 32 sources and a 5-bit code.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  when 1, `req_in` is captured into pending; when 0, `req_in` is ignored and the handshake keeps running
- req_in  input  32  request pulses; bit i set means source i requests service
- out_ready  input  1  consumer accepts the presented code this cycle
- out_valid  output  1  `out_code` and `out_onehot` are valid
- out_code  output  5  binary index of the source being presented
- out_onehot  output  32  `1 << out_code` while `out_valid=1`; all-zero otherwise
- pending  output  32  registered pending vector, excluding the entry currently presented

## Operation
- State register with two states, IDLE and PRESENT. Registers: `pending[31:0]`, `out_code[4:0]`, `out_valid`.
- Selection: `sel` is the lowest set bit index of the registered `pending` value. `any` = |`pending`. Requests arriving in the current cycle are not selectable in that cycle.
- Load: `out_code` <= `sel`, `out_valid` <= 1, and bit `sel` is cleared from pending in the same edge.
- Pending update each edge: `pending` <= (`pending` & ~`load_mask`) | (`enable` ? `req_in` : 0). `load_mask` is the one-hot of `sel` when a load occurs, else 0.
- Set wins over clear. If `req_in[sel]` is high in the load cycle, bit `sel` stays pending as a new, later request.
- IDLE: if `any`, load and go to PRESENT. Otherwise stay; `out_valid`=0.
- PRESENT, `out_ready`=0: hold `out_code` and `out_valid` stable. Pending still accumulates.
- PRESENT, `out_ready`=1 with `any`: load the next entry and stay in PRESENT. This gives back-to-back service.
- PRESENT, `out_ready`=1 without `any`: `out_valid` <= 0 and go to IDLE.
- Repeat requests from a bit already pending merge into that single pending bit. No count is kept.
- A request on the bit currently presented sets its pending bit. It is served again after the current handshake.
- `out_onehot` is decoded combinationally from the registered `out_code` and gated by `out_valid`.

## Timing
- Reset (asynchronous, any time including mid-handshake) clears everything immediately, without waiting for a clock edge:
  - state = IDLE
  - `pending` = 0
  - `out_code` = 5'd0
  - `out_valid` = 0
  - `out_onehot` = 0
- Latency from IDLE:
  - `req_in` asserted in cycle N is in `pending` from cycle N+1.
  - `out_valid`=1 with the code appears in cycle N+2.
- Throughput is one code per cycle while `out_ready` is held at 1 and pending is non-empty.
- Handshake: a transfer happens on an edge where `out_valid` and `out_ready` are both 1.
  - The producer never drops `out_valid` or changes `out_code` without a transfer.
  - `out_ready` may be high while `out_valid`=0; it has no effect then.
- When `pending` holds all 32 bits, 32 accepted transfers drain it in codes 0..31 ascending, provided no new requests arrive.
- Priority is strict lowest-index. Starvation of high indices under continuous low-index requests is intended behaviour.

## Test plan
- Reset check: with reset=1, drive `req_in`=32'hFFFFFFFF and `enable`=1 → `out_valid`=0, `pending`=0, `out_code`=0 throughout reset.
- Single request: `req_in`=32'h0001_0000 for 1 cycle, `out_ready`=1 → `out_valid` high two cycles later for 1 cycle, with `out_code`=16 and `out_onehot`=32'h0001_0000; then `pending`=0.
- Multiple requests under backpressure:
  - Pulse `req_in`=32'h8000_0005 once, with `out_ready`=0 for 5 cycles, then 1.
  - `out_code` must hold 0 stably through the stall.
  - Then the sequence 2, 31 follows on consecutive cycles, and `out_valid` drops afterwards.
- Enable gating: `enable`=0 with `req_in`=32'hFFFFFFFF for 3 cycles → `pending` stays 0 and there is no `out_valid`. Raising `enable` for one cycle then yields 32 transfers, codes 0..31 in order.
- Simultaneous set/clear: while code 3 is presented and accepted, pulse `req_in[3]` and `req_in[1]` in the same cycle → the next codes are 1 then 3.
- Mid-operation reset: assert reset asynchronously with 10 bits pending and `out_valid`=1 → all outputs are 0 immediately. After release, there are no transfers until new requests arrive.
